// File: rtl/bus_alu_pkg.sv
// Shared definitions for the single-bus ALU sequencer: op codes, FSM state
// encoding and register index width helper.
package bus_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHRA = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_NEG  = 4'd9;
    localparam logic [3:0] OP_NOT  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_T4   = 3'd4;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_alu_sequencer_unit.sv
// Combinational ALU: produces the 2W-wide Z value (zhi:zlo) from Y (a) and
// the bus (b). Only MUL and DIV produce a non-zero upper half.
module bus_alu_unit
    import bus_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] zhi,
    output logic [WIDTH-1:0] zlo
);

    localparam int SHW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

    logic [SHW-1:0]           sh;
    logic signed [WIDTH-1:0]  a_s;
    logic signed [WIDTH-1:0]  b_s;
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0]       prod;
    logic [WIDTH-1:0]         quot;
    logic [WIDTH-1:0]         rem;

    assign sh    = b[SHW-1:0];
    assign a_s   = a;
    assign b_s   = b;
    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod  = a_ext * b_ext;

    // MIN / -1 is pinned explicitly so the quotient wraps instead of trapping.
    always_comb begin
        quot = '1;
        rem  = a;
        if (b == '0) begin
            quot = '1;
            rem  = a;
        end else if ((a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b)) begin
            quot = a;
            rem  = '0;
        end else begin
            quot = a_s / b_s;
            rem  = a_s % b_s;
        end
    end

    always_comb begin
        zhi = '0;
        zlo = '0;
        case (op)
            OP_ADD:  zlo = a + b;
            OP_SUB:  zlo = a - b;
            OP_AND:  zlo = a & b;
            OP_OR:   zlo = a | b;
            OP_SHR:  zlo = a >> sh;
            OP_SHRA: zlo = a_s >>> sh;
            OP_SHL:  zlo = a << sh;
            OP_ROR:  zlo = WIDTH'({a, a} >> sh);
            OP_ROL:  zlo = WIDTH'(({a, a} << sh) >> WIDTH);
            OP_NEG:  zlo = -a;
            OP_NOT:  zlo = ~a;
            OP_MUL: begin
                zhi = prod[2*WIDTH-1:WIDTH];
                zlo = prod[WIDTH-1:0];
            end
            OP_DIV: begin
                zhi = rem;
                zlo = quot;
            end
            default: begin
                zhi = '0;
                zlo = '0;
            end
        endcase
    end

endmodule

// File: rtl/bus_alu_sequencer.sv
// Single-bus datapath with register file, HI/LO, Y, Z and a micro-sequencer
// running one register-to-register instruction per start/done transaction.
module bus_alu_sequencer
    import bus_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 16,
    parameter int ZERO_R0 = 0
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic                          start,
    input  logic [3:0]                    op,
    input  logic [idx_width(NREGS)-1:0]   rd,
    input  logic [idx_width(NREGS)-1:0]   rs,
    input  logic [idx_width(NREGS)-1:0]   rt,
    input  logic                          ld_en,
    input  logic [idx_width(NREGS)-1:0]   ld_addr,
    input  logic [WIDTH-1:0]              ld_data,
    input  logic [idx_width(NREGS)-1:0]   dbg_addr,
    output logic [WIDTH-1:0]              dbg_data,
    output logic [WIDTH-1:0]              hi,
    output logic [WIDTH-1:0]              lo,
    output logic                          busy,
    output logic                          done
);

    localparam int IW = idx_width(NREGS);

    logic [2:0]         state_q, state_d;
    logic [3:0]         op_q;
    logic [IW-1:0]      rd_q, rs_q, rt_q;
    logic [WIDTH-1:0]   y_q, hi_q, lo_q;
    logic [2*WIDTH-1:0] z_q;
    logic               done_q;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   rview  [NREGS];

    logic [WIDTH-1:0]   bus;
    logic [WIDTH-1:0]   alu_hi, alu_lo;
    logic               is_muldiv, is_reserved;
    logic               wr_en;
    logic [IW-1:0]      wr_addr;
    logic [WIDTH-1:0]   wr_data;

    assign is_muldiv   = (op_q == OP_MUL) || (op_q == OP_DIV);
    assign is_reserved = (op_q > OP_DIV);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_regs
            assign rview[gi] = (ZERO_R0 != 0 && gi == 0) ? '0 : regs_q[gi];

            always_ff @(posedge clock) begin
                if (clear) begin
                    regs_q[gi] <= '0;
                end else if (wr_en && wr_addr == IW'(gi)) begin
                    regs_q[gi] <= wr_data;
                end
            end
        end
    endgenerate

    always_comb begin
        case (state_q)
            S_T1:    bus = rview[rs_q];
            S_T2:    bus = rview[rt_q];
            S_T3:    bus = z_q[WIDTH-1:0];
            S_T4:    bus = z_q[2*WIDTH-1:WIDTH];
            default: bus = '0;
        endcase
    end

    bus_alu_unit #(.WIDTH(WIDTH)) u_alu (
        .a   (y_q),
        .b   (bus),
        .op  (op_q),
        .zhi (alu_hi),
        .zlo (alu_lo)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = is_muldiv ? S_T4 : S_IDLE;
            S_T4:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Host loads and write-back never collide: loads only happen in IDLE.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rd_q;
        wr_data = bus;
        if (state_q == S_IDLE && ld_en) begin
            wr_en   = 1'b1;
            wr_addr = ld_addr;
            wr_data = ld_data;
        end else if (state_q == S_T3 && !is_muldiv && !is_reserved) begin
            wr_en   = 1'b1;
        end
        if (ZERO_R0 != 0 && wr_addr == '0) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            y_q     <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_T3 && !is_muldiv) || (state_q == S_T4);
            if (state_q == S_IDLE && start) begin
                op_q <= op;
                rd_q <= rd;
                rs_q <= rs;
                rt_q <= rt;
            end
            if (state_q == S_T1) y_q <= bus;
            if (state_q == S_T2) z_q <= {alu_hi, alu_lo};
            if (state_q == S_T3 && is_muldiv) lo_q <= bus;
            if (state_q == S_T4) hi_q <= bus;
        end
    end

    assign dbg_data = rview[dbg_addr];
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

endmodule

// File: doc/bus_alu_sequencer.md
Name: bus_alu_sequencer

Overview:
- Parametrised next-generation single-bus datapath core.
- Contains NREGS general registers, HI/LO, Y, a 2W-wide Z and an ALU.
- A built-in micro-sequencer executes one register-to-register ALU instruction as a start/busy/done transaction. It drives the internal bus select and enable signals itself, so no external per-register strobes are needed.
- Sits between the instruction decoder (which issues op/rd/rs/rt) and the host load/debug interface.

Parameters:
- WIDTH, 32, datapath and register width.
- NREGS, 16, number of general registers (power of two, at least 2).
- ZERO_R0, 0, when 1, R0 always reads 0 and writes to it are discarded.

Ports:
- clock  in  1  single system clock, rising-edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  instruction request, sampled only in IDLE.
- op  in  4  ALU operation code.
- rd, rs, rt  in  $clog2(NREGS) each  destination and source register indices.
- ld_en  in  1  host register load strobe.
- ld_addr  in  $clog2(NREGS)  host load index.
- ld_data  in  WIDTH  host load value.
- dbg_addr  in  $clog2(NREGS)  combinational debug read index.
- dbg_data  out  WIDTH  contents of R[dbg_addr].
- hi, lo  out  WIDTH  HI and LO register contents.
- busy  out  1  sequencer is executing.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock named clock; reset port clear is synchronous and active-high.
- Reset: all registers, HI, LO, Y and Z become 0; state IDLE; busy=0, done=0. This applies mid-operation: the instruction is abandoned and its write-back is lost.
- FSM states: IDLE, T1, T2, T3, T4.
  - IDLE: start=1 latches op/rd/rs/rt and goes to T1; busy=1 from the next cycle.
  - T1: bus = R[rs]; Y <= bus; go to T2.
  - T2: bus = R[rt]; Z <= ALU(Y, bus); go to T3.
  - T3: bus = Zlow.
    - ADD..NOT: R[rd] <= Zlow; go to IDLE with done=1.
    - MUL, DIV: LO <= Zlow; go to T4.
    - Reserved ops: no write; go to IDLE with done=1.
  - T4: bus = Zhigh; HI <= Zhigh; go to IDLE with done=1.
- Latency: start edge to result visible is 3 edges (4 for MUL/DIV).
- done and busy:
  - done is high for exactly the one cycle in which the result is first visible.
  - busy=0 during that cycle, so a back-to-back start is accepted then.
- Op codes (signed two's complement; shift/rotate amount is the low $clog2(WIDTH) bits of Rt):
  - 0 ADD, 1 SUB (Rs-Rt), 2 AND, 3 OR.
  - 4 SHR logical, 5 SHRA arithmetic, 6 SHL, 7 ROR, 8 ROL.
  - 9 NEG (-Rs, Rt ignored), 10 NOT (~Rs).
  - 11 MUL: signed 2W product; Zhigh is the upper half, Zlow the lower.
  - 12 DIV: signed, truncating; Zlow = quotient, Zhigh = remainder (sign of dividend).
  - DIV by zero: quotient all-ones, remainder = Rs.
  - 13-15: reserved (no write, done still pulses).
- No overflow flags; results wrap modulo 2^WIDTH.
- Non-MUL/DIV ops set Zhigh to 0.
- Host load:
  - ld_en is honoured only when busy=0.
  - ld_en while busy is dropped, not queued.
  - ld_en together with start in IDLE: the load is performed and T1 reads the new value.
- start while busy is ignored.
- Operand reads: rs/rt/rd are captured at start; later changes to those inputs have no effect.
- ZERO_R0=1: R[0] reads 0 on the bus and on dbg_data; loads and write-backs to index 0 are discarded.
- rd==rs or rd==rt is legal: sources are consumed before write-back.

Decomposition:
- Shared package bus_alu_pkg holds:
  - op-code localparams (OP_ADD..OP_DIV);
  - FSM state encoding;
  - a function computing index width from NREGS.
- One sub-module, bus_alu_unit: combinational, parametrised by WIDTH, inputs a, b, op, outputs zhi/zlo. It is instantiated once.
- Register file and bus mux stay inline in bus_alu_sequencer.

Test Plan:
- Reset and load:
  - clear mid-T2 of an ADD -> next cycle busy=0, done=0, dbg_data=0 for all indices, hi=lo=0.
  - Load R2=5, R3=7, then start ADD rd=1 rs=2 rt=3 -> done on the 3rd edge after start; R1=12.
- Arithmetic and shifts:
  - R2=0xFFFFFFFF, R3=0x00000002: MUL rd=x -> lo=0xFFFFFFFE, hi=0xFFFFFFFF, done at the 4th edge.
  - R2=0xFFFFFFFF, R3=0x00000002: SHRA -> R1=0xFFFFFFFF.
  - R2=0xFFFFFFFF, R3=0x00000002: ROL -> R1=0xFFFFFFFF.
- Division:
  - R2=-7, R3=2: DIV -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - R3=0: DIV -> lo=0xFFFFFFFF, hi=R2.
- Handshake:
  - start held high continuously -> a new instruction is accepted in each done cycle.
  - ld_en R4=9 while busy -> R4 unchanged.
- ZERO_R0=1:
  - load R0=0x55 -> dbg_data(0)=0.
  - ADD rd=0 -> R0 stays 0.
  - ADD rd=1 rs=0 rt=3 (R3=7) -> R1=7.
